// File: rtl/ex_stage_pkg.sv
// Shared Y86 execute-stage definitions: instruction codes, ALU function codes,
// condition codes, register sentinel and condition-code bit positions.
package ex_stage_pkg;

  // Instruction codes (low nibble of icode)
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVL = 4'h2;
  localparam logic [3:0] IIRMOVL = 4'h3;
  localparam logic [3:0] IRMMOVL = 4'h4;
  localparam logic [3:0] IMRMOVL = 4'h5;
  localparam logic [3:0] IOPL    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHL  = 4'hA;
  localparam logic [3:0] IPOPL   = 4'hB;

  // ALU function codes
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  // Condition codes for jXX / cmovXX
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  // "No register" destination
  localparam logic [7:0] RNONE = 8'h0F;

  // Bit positions inside the {ZF,SF,OF} condition-code vector
  localparam int unsigned CC_ZF = 2;
  localparam int unsigned CC_SF = 1;
  localparam int unsigned CC_OF = 0;

  // Value the condition codes take out of reset: ZF=1, SF=0, OF=0
  localparam logic [2:0] CC_RESET = 3'b100;

  // Halt state machine
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } ex_state_t;

  // Icodes above IPOPL are undefined and stop the machine like halt
  function automatic logic icode_valid(input logic [3:0] ic);
    return ic <= IPOPL;
  endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational Y86 ALU: valE = aluB op aluA, plus the ZF/SF/OF flags of the
// result. Unknown function codes produce zero with OF clear.
module ex_alu
  import ex_stage_pkg::*;
#(
  parameter int ALU_W = 32
) (
  input  logic signed [ALU_W-1:0] alu_a,
  input  logic signed [ALU_W-1:0] alu_b,
  input  logic        [3:0]       alu_fun,
  output logic signed [ALU_W-1:0] val_e,
  output logic                    zf,
  output logic                    sf,
  output logic                    of
);

  localparam int MSB = ALU_W - 1;

  // Result and overflow; carry out of the adder is deliberately dropped
  always_comb begin
    val_e = '0;
    of    = 1'b0;
    case (alu_fun)
      ALU_ADD: begin
        val_e = alu_b + alu_a;
        of    = (alu_a[MSB] == alu_b[MSB]) && (val_e[MSB] != alu_a[MSB]);
      end
      ALU_SUB: begin
        val_e = alu_b - alu_a;
        of    = (alu_a[MSB] != alu_b[MSB]) && (val_e[MSB] != alu_b[MSB]);
      end
      ALU_AND: val_e = alu_b & alu_a;
      ALU_XOR: val_e = alu_b ^ alu_a;
      default: val_e = '0;
    endcase
  end

  assign zf = (val_e == '0);
  assign sf = val_e[MSB];

endmodule

// File: rtl/ex_stage.sv
// Y86 execute stage: ALU operand muxes, condition-code register, branch/move
// condition evaluation, cmov destination squash and the sticky halt state.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int ALU_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ex_icode,
  input  logic [7:0]       ex_ifun,
  input  logic [ALU_W-1:0] ex_valA,
  input  logic [ALU_W-1:0] ex_valB,
  input  logic [ALU_W-1:0] ex_valC,
  input  logic [7:0]       ex_dstE,
  input  logic             m_exc,
  input  logic             w_exc,
  output logic [ALU_W-1:0] e_valE,
  output logic             e_cnd,
  output logic [7:0]       e_dstE,
  output logic [2:0]       e_cc,
  output logic             e_halted
);

  localparam logic signed [ALU_W-1:0] STK_DEC = ALU_W'(-4);
  localparam logic signed [ALU_W-1:0] STK_INC = ALU_W'(4);

  logic [3:0] icode;
  logic [3:0] ifun;
  logic       unused_hi;

  assign icode     = ex_icode[3:0];
  assign ifun      = ex_ifun[3:0];
  assign unused_hi = ^{ex_icode[7:4], ex_ifun[7:4]};

  logic signed [ALU_W-1:0] alu_a;
  logic signed [ALU_W-1:0] alu_b;
  logic        [3:0]       alu_fun;
  logic signed [ALU_W-1:0] alu_res;
  logic                    alu_zf;
  logic                    alu_sf;
  logic                    alu_of;

  logic [2:0] cc;
  logic       cc_upd;
  logic       cnd;
  ex_state_t  state;
  ex_state_t  state_nxt;

  // Operand A: register, constant, or stack-pointer step
  always_comb begin
    alu_a = '0;
    case (icode)
      IRRMOVL, IOPL:           alu_a = ex_valA;
      IIRMOVL, IRMMOVL,
      IMRMOVL:                 alu_a = ex_valC;
      ICALL, IPUSHL:           alu_a = STK_DEC;
      IRET, IPOPL:             alu_a = STK_INC;
      default:                 alu_a = '0;
    endcase
  end

  // Operand B: register B for memory, arithmetic and stack instructions
  always_comb begin
    alu_b = '0;
    case (icode)
      IRMMOVL, IMRMOVL, IOPL, ICALL,
      IRET, IPUSHL, IPOPL:     alu_b = ex_valB;
      default:                 alu_b = '0;
    endcase
  end

  assign alu_fun = (icode == IOPL) ? ifun : ALU_ADD;

  ex_alu #(
    .ALU_W (ALU_W)
  ) u_alu (
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_fun (alu_fun),
    .val_e   (alu_res),
    .zf      (alu_zf),
    .sf      (alu_sf),
    .of      (alu_of)
  );

  assign e_valE = alu_res;

  // Only a well-formed OPl updates CC, and only while no older instruction
  // has faulted and the machine has not halted
  assign cc_upd = (icode == IOPL) && (ifun <= ALU_XOR) &&
                  !m_exc && !w_exc && (state == ST_RUN);

  // Condition-code register
  always_ff @(posedge clk) begin
    if (rst) begin
      cc <= CC_RESET;
    end else if (cc_upd) begin
      cc <= {alu_zf, alu_sf, alu_of};
    end
  end

  assign e_cc = cc;

  // Condition evaluated against the CC value before this cycle's update
  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = (cc[CC_SF] ^ cc[CC_OF]) | cc[CC_ZF];
      C_L:     cnd = cc[CC_SF] ^ cc[CC_OF];
      C_E:     cnd = cc[CC_ZF];
      C_NE:    cnd = !cc[CC_ZF];
      C_GE:    cnd = !(cc[CC_SF] ^ cc[CC_OF]);
      C_G:     cnd = !(cc[CC_SF] ^ cc[CC_OF]) && !cc[CC_ZF];
      default: cnd = 1'b0;
    endcase
  end

  assign e_cnd  = ((icode == IRRMOVL) || (icode == IJXX)) ? cnd : 1'b0;
  assign e_dstE = ((icode == IRRMOVL) && !cnd) ? RNONE : ex_dstE;

  // Halt state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Halt next-state: halt or an undefined icode stops the machine for good
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if ((icode == IHALT) || !icode_valid(icode)) begin
          state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RUN;
    endcase
  end

  assign e_halted = (state == ST_HALTED);

endmodule
